// File: rtl/fsm_burst_ctrl.sv
// Burst controller: request, arm, programmable-length run, timed hold with bounded re-arm retries.
// Optional abort path is compiled in when FSM_ABORT_EN is defined.
module fsm_burst_ctrl #(
  parameter int CNT_W       = 4,
  parameter int HOLD_CYCLES = 3,
  parameter int RETRY_MAX   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic [CNT_W-1:0] len,
  input  logic             abort,
  output logic             out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] remain
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_RUN  = 3'd2,
    S_HOLD = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);
  localparam logic [2:0]       RETRY_LIM = 3'(RETRY_MAX);

  state_t           state_q;
  logic [CNT_W-1:0] remain_q;
  logic [CNT_W-1:0] hold_q;
  logic [2:0]       retry_q;
  logic             err_q;
  logic             abort_s;

`ifdef FSM_ABORT_EN
  // Abort only matters while a burst is pending or active.
  assign abort_s = abort & ((state_q == S_ARM) | (state_q == S_RUN) | (state_q == S_HOLD));
`else
  logic unused_abort_s;
  assign unused_abort_s = abort;
  assign abort_s        = 1'b0;
`endif

  // Controller state, burst/hold/retry counters and the err pulse flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      remain_q <= CNT_ZERO;
      hold_q   <= CNT_ZERO;
      retry_q  <= 3'd0;
      err_q    <= 1'b0;
    end else if (abort_s) begin
      state_q  <= S_IDLE;
      remain_q <= CNT_ZERO;
      hold_q   <= CNT_ZERO;
      retry_q  <= 3'd0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          retry_q <= 3'd0;
          if (in) begin
            state_q <= S_ARM;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ARM: begin
          if (in) begin
            if (len != CNT_ZERO) begin
              state_q  <= S_RUN;
              remain_q <= len;
            end else begin
              state_q <= S_DONE;
            end
          end else begin
            state_q <= S_HOLD;
            hold_q  <= HOLD_LOAD;
          end
        end
        S_RUN: begin
          // Terminal count at 1 so the counter never wraps below zero.
          if (remain_q <= CNT_ONE) begin
            state_q  <= S_DONE;
            remain_q <= CNT_ZERO;
          end else begin
            remain_q <= remain_q - CNT_ONE;
          end
        end
        S_HOLD: begin
          if (hold_q <= CNT_ONE) begin
            hold_q <= CNT_ZERO;
            if (retry_q < RETRY_LIM) begin
              state_q <= S_ARM;
              retry_q <= retry_q + 3'd1;
            end else begin
              state_q <= S_IDLE;
              retry_q <= 3'd0;
              err_q   <= 1'b1;
            end
          end else begin
            hold_q <= hold_q - CNT_ONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          retry_q <= 3'd0;
        end
        default: begin
          state_q  <= S_IDLE;
          remain_q <= CNT_ZERO;
          hold_q   <= CNT_ZERO;
          retry_q  <= 3'd0;
        end
      endcase
    end
  end

  assign out     = (state_q != S_IDLE);
  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign err     = err_q;
  assign state_o = state_q;
  assign remain  = remain_q;

endmodule
